mem_port_responder: RTL and testbench
=====================================

// Module: mem_port_responder
// PURPOSE
//  Memory-side responder for the pipeline's split I/D request interface. Serves
//  i_mem_read (fetch) and d_mem_read/d_mem_write (MEM stage) from one shared
//  single-ported physical memory, returning one-cycle i_mem_resp/d_mem_resp pulses.
//  Sits between the pipeline datapath (whose hazard unit consumes the resps) and pmem.
// PARAMETERS
//  ADDR_W        16  address width, I, D and pmem sides
//  DATA_W        16  data width, I, D and pmem sides
//  D_STREAK_MAX  4   consecutive D grants allowed while an I request waits
// PORTS
//  clk               in   1       clock; all state updates on rising edge
//  rst               in   1       asynchronous, active-high reset
//  i_mem_read        in   1       fetch request, level, held until i_mem_resp or dropped
//  i_mem_address     in   ADDR_W  fetch address
//  i_mem_rdata       out  DATA_W  fetch data, valid while i_mem_resp=1
//  i_mem_resp        out  1       one-cycle fetch completion pulse
//  d_mem_read        in   1       data read request, level
//  d_mem_write       in   1       data write request, level
//  d_mem_byte_enable in   2       write byte lanes, [1]=high byte
//  d_mem_address     in   ADDR_W  data address
//  d_mem_wdata       in   DATA_W  write data
//  d_mem_rdata       out  DATA_W  read data, valid while d_mem_resp=1
//  d_mem_resp        out  1       one-cycle data completion pulse
//  pmem_read         out  1       physical read, held until pmem_resp
//  pmem_write        out  1       physical write, held until pmem_resp
//  pmem_address      out  ADDR_W  physical address
//  pmem_wdata        out  DATA_W  physical write data
//  pmem_byte_enable  out  2       physical write lanes (2'b11 on reads)
//  pmem_rdata        in   DATA_W  physical read data, valid with pmem_resp
//  pmem_resp         in   1       physical completion, one cycle, any latency >=1
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, d_streak 0. Asserts asynchronously; an in-flight
//   pmem access is abandoned (pmem_read/write drop at once). No resp is issued for it.
//  FSM IDLE -> I_BUSY | D_BUSY -> RESP -> IDLE. All outputs are registered.
//  IDLE: sample requests. Grant D if (d_mem_read|d_mem_write) and not
//   (i_mem_read && d_streak==D_STREAK_MAX). Otherwise grant I if i_mem_read. Else stay.
//   On grant, latch address, wdata, byte_enable and op. pmem_* assert from next cycle.
//   d_mem_read and d_mem_write both high: treated as write.
//  d_streak: +1 on each D grant, saturating at D_STREAK_MAX. Cleared on every I grant.
//   At saturation with no I request pending, D is still granted.
//  I_BUSY/D_BUSY: pmem_* held constant from latched values. Request-side address and
//   data changes are ignored. On pmem_resp: drop pmem_read/write next cycle, latch
//   pmem_rdata into the granted port's rdata, go to RESP.
//   Resp pulse in RESP is issued only if the granted request is still asserted in the
//   pmem_resp cycle. Otherwise the result is discarded: no pulse, rdata unchanged.
//   This covers a fetch dropped by the hazard unit on a control transfer or flush.
//  RESP (exactly 1 cycle): i_mem_resp or d_mem_resp = 1 (never both). All requests
//   ignored this cycle, because the requester still shows the stale request. Next: IDLE.
//  Latency: request in IDLE at cycle 0, pmem_resp at cycle k (k>=1) -> resp at k+1.
//   Minimum 2 cycles. The next grant is no earlier than cycle k+2.
//  rdata outputs hold their last delivered value between pulses.
//  Unused ports stay quiet: the non-granted side sees no pmem activity.
// TESTING
//  1 I alone: i_mem_read@0x1000 c0, pmem_resp c3 rdata 0xBEEF -> pmem_read c1..c3
//    addr 0x1000; i_mem_resp=1, i_mem_rdata=0xBEEF in c4 only; d_mem_resp stays 0.
//  2 I+D same cycle (d_mem_read@0x2000, i@0x1000) -> D served first (pmem_address
//    0x2000), d_mem_resp pulse; I granted in the IDLE after RESP, i_mem_resp follows.
//  3 D_STREAK_MAX=4: D requests continuous, I pending -> grant order D,D,D,D,I,D...;
//    d_streak resets after the I grant.
//  4 Drop: i_mem_read falls in I_BUSY before pmem_resp -> pmem completes, no
//    i_mem_resp, i_mem_rdata unchanged; the next request is served normally.
//  5 Write: d_mem_write, be=2'b10, addr 0x2001, wdata 0xAB00 -> pmem_write,
//    pmem_byte_enable 2'b10, pmem_wdata 0xAB00; one d_mem_resp; addr change mid-busy ignored.
//  6 rst pulse mid D_BUSY -> all outputs 0 immediately, no resp; new I request is
//    served from IDLE with standard latency.

Source files
------------

// File: rtl/mem_port_responder.sv
// Memory-side responder that arbitrates split fetch/data requests onto one
// single-ported physical memory and returns one-cycle completion pulses.

module mem_port_responder_checker (
    input logic clk,
    input logic rst,
    input logic i_mem_resp,
    input logic d_mem_resp,
    input logic pmem_read,
    input logic pmem_write
);

    // Completion pulses are exclusive and last exactly one cycle.
    resp_exclusive_a: assert property (@(posedge clk) disable iff (rst)
        !(i_mem_resp && d_mem_resp));
    i_resp_pulse_a: assert property (@(posedge clk) disable iff (rst)
        i_mem_resp |=> !i_mem_resp);
    d_resp_pulse_a: assert property (@(posedge clk) disable iff (rst)
        d_mem_resp |=> !d_mem_resp);
    pmem_op_exclusive_a: assert property (@(posedge clk) disable iff (rst)
        !(pmem_read && pmem_write));

endmodule

module mem_port_responder #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int D_STREAK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [1:0]        d_mem_byte_enable,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [1:0]        pmem_byte_enable,
    input  logic [DATA_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam int SW = $clog2(D_STREAK_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     d_streak_q, d_streak_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [ADDR_W-1:0] pmem_address_q, pmem_address_d;
    logic [DATA_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [1:0]        pmem_byte_enable_q, pmem_byte_enable_d;
    logic [DATA_W-1:0] i_mem_rdata_q, i_mem_rdata_d;
    logic              i_mem_resp_q, i_mem_resp_d;
    logic [DATA_W-1:0] d_mem_rdata_q, d_mem_rdata_d;
    logic              d_mem_resp_q, d_mem_resp_d;

    logic d_req_s;
    logic streak_full_s;
    logic d_grant_s;
    logic i_grant_s;

    // Arbitration: D wins unless it has starved a waiting fetch for too long.
    always_comb begin
        d_req_s       = d_mem_read | d_mem_write;
        streak_full_s = (d_streak_q == SW'(D_STREAK_MAX));
        d_grant_s     = d_req_s & ~(i_mem_read & streak_full_s);
        i_grant_s     = ~d_grant_s & i_mem_read;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (d_grant_s) begin
                    state_d = ST_D_BUSY;
                end else if (i_grant_s) begin
                    state_d = ST_I_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_I_BUSY, ST_D_BUSY: begin
                if (pmem_resp) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; everything holds unless the state acts on it.
    always_comb begin
        d_streak_d         = d_streak_q;
        pmem_read_d        = pmem_read_q;
        pmem_write_d       = pmem_write_q;
        pmem_address_d     = pmem_address_q;
        pmem_wdata_d       = pmem_wdata_q;
        pmem_byte_enable_d = pmem_byte_enable_q;
        i_mem_rdata_d      = i_mem_rdata_q;
        d_mem_rdata_d      = d_mem_rdata_q;
        i_mem_resp_d       = 1'b0;
        d_mem_resp_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (d_grant_s) begin
                    // Read and write together count as a write.
                    pmem_read_d        = ~d_mem_write;
                    pmem_write_d       = d_mem_write;
                    pmem_address_d     = d_mem_address;
                    pmem_wdata_d       = d_mem_write ? d_mem_wdata : {DATA_W{1'b0}};
                    pmem_byte_enable_d = d_mem_write ? d_mem_byte_enable : 2'b11;
                    if (streak_full_s) begin
                        d_streak_d = d_streak_q;
                    end else begin
                        d_streak_d = d_streak_q + SW'(1);
                    end
                end else if (i_grant_s) begin
                    pmem_read_d        = 1'b1;
                    pmem_write_d       = 1'b0;
                    pmem_address_d     = i_mem_address;
                    pmem_wdata_d       = {DATA_W{1'b0}};
                    pmem_byte_enable_d = 2'b11;
                    d_streak_d         = {SW{1'b0}};
                end else begin
                    d_streak_d = d_streak_q;
                end
            end
            ST_I_BUSY: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    // A fetch withdrawn before completion is silently discarded.
                    if (i_mem_read) begin
                        i_mem_rdata_d = pmem_rdata;
                        i_mem_resp_d  = 1'b1;
                    end else begin
                        i_mem_resp_d  = 1'b0;
                    end
                end else begin
                    i_mem_resp_d = 1'b0;
                end
            end
            ST_D_BUSY: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (d_req_s) begin
                        d_mem_rdata_d = pmem_rdata;
                        d_mem_resp_d  = 1'b1;
                    end else begin
                        d_mem_resp_d  = 1'b0;
                    end
                end else begin
                    d_mem_resp_d = 1'b0;
                end
            end
            ST_RESP: begin
                i_mem_resp_d = 1'b0;
                d_mem_resp_d = 1'b0;
            end
            default: begin
                pmem_read_d  = 1'b0;
                pmem_write_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and arbitration history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_streak_q         <= {SW{1'b0}};
            pmem_read_q        <= 1'b0;
            pmem_write_q       <= 1'b0;
            pmem_address_q     <= {ADDR_W{1'b0}};
            pmem_wdata_q       <= {DATA_W{1'b0}};
            pmem_byte_enable_q <= 2'b00;
            i_mem_rdata_q      <= {DATA_W{1'b0}};
            i_mem_resp_q       <= 1'b0;
            d_mem_rdata_q      <= {DATA_W{1'b0}};
            d_mem_resp_q       <= 1'b0;
        end else begin
            d_streak_q         <= d_streak_d;
            pmem_read_q        <= pmem_read_d;
            pmem_write_q       <= pmem_write_d;
            pmem_address_q     <= pmem_address_d;
            pmem_wdata_q       <= pmem_wdata_d;
            pmem_byte_enable_q <= pmem_byte_enable_d;
            i_mem_rdata_q      <= i_mem_rdata_d;
            i_mem_resp_q       <= i_mem_resp_d;
            d_mem_rdata_q      <= d_mem_rdata_d;
            d_mem_resp_q       <= d_mem_resp_d;
        end
    end

    assign pmem_read        = pmem_read_q;
    assign pmem_write       = pmem_write_q;
    assign pmem_address     = pmem_address_q;
    assign pmem_wdata       = pmem_wdata_q;
    assign pmem_byte_enable = pmem_byte_enable_q;
    assign i_mem_rdata      = i_mem_rdata_q;
    assign i_mem_resp       = i_mem_resp_q;
    assign d_mem_rdata      = d_mem_rdata_q;
    assign d_mem_resp       = d_mem_resp_q;

    mem_port_responder_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .i_mem_resp (i_mem_resp_q),
        .d_mem_resp (d_mem_resp_q),
        .pmem_read  (pmem_read_q),
        .pmem_write (pmem_write_q)
    );

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder: a behavioural pmem with programmable
// latency, a response scoreboard and cycle-exact checks of each scenario.

module tb_mem_port_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic [15:0] i_mem_rdata;
    logic        i_mem_resp;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic [15:0] d_mem_rdata;
    logic        d_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_rdata = 16'h0000;
    logic        pmem_resp  = 1'b0;

    typedef struct packed {
        logic        is_d;
        logic        chk_data;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] glog[$];
    logic [15:0] mem [logic [15:0]];
    int          lat = 1;
    int          cnt = 0;
    int          checks = 0;
    int          errors = 0;
    bit          prev_busy = 1'b0;
    exp_t        mon_e;
    bit          mon_have;
    logic [15:0] mdl_word;

    mem_port_responder #(.ADDR_W(16), .DATA_W(16), .D_STREAK_MAX(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .i_mem_read        (i_mem_read),
        .i_mem_address     (i_mem_address),
        .i_mem_rdata       (i_mem_rdata),
        .i_mem_resp        (i_mem_resp),
        .d_mem_read        (d_mem_read),
        .d_mem_write       (d_mem_write),
        .d_mem_byte_enable (d_mem_byte_enable),
        .d_mem_address     (d_mem_address),
        .d_mem_wdata       (d_mem_wdata),
        .d_mem_rdata       (d_mem_rdata),
        .d_mem_resp        (d_mem_resp),
        .pmem_read         (pmem_read),
        .pmem_write        (pmem_write),
        .pmem_address      (pmem_address),
        .pmem_wdata        (pmem_wdata),
        .pmem_byte_enable  (pmem_byte_enable),
        .pmem_rdata        (pmem_rdata),
        .pmem_resp         (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_d, input logic chk, input logic [15:0] data);
        exp_t e;
        e.is_d     = is_d;
        e.chk_data = chk;
        e.data     = data;
        sb.push_back(e);
    endtask

    task automatic wait_resp(input int max_cyc, input string tag);
        bit got;
        int n;
        got = 1'b0;
        n   = 0;
        while (!got && n < max_cyc) begin
            tick();
            n++;
            got = i_mem_resp | d_mem_resp;
        end
        check(tag, {31'd0, got}, 32'd1);
    endtask

    function automatic logic [15:0] rd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h0000;
    endfunction

    // Physical memory: answers after 'lat' cycles of a held request.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            pmem_resp = 1'b0;
            cnt       = 0;
        end else if (pmem_resp) begin
            pmem_resp = 1'b0;
            cnt       = 0;
        end else if (pmem_read || pmem_write) begin
            cnt++;
            if (cnt >= lat) begin
                if (pmem_write) begin
                    mdl_word = rd(pmem_address);
                    if (pmem_byte_enable[0]) mdl_word[7:0]  = pmem_wdata[7:0];
                    if (pmem_byte_enable[1]) mdl_word[15:8] = pmem_wdata[15:8];
                    mem[pmem_address] = mdl_word;
                    pmem_rdata = 16'h0000;
                end else begin
                    pmem_rdata = rd(pmem_address);
                end
                pmem_resp = 1'b1;
                cnt       = 0;
            end
        end
    end

    // Response monitor: pops the scoreboard and logs grant order.
    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
        end else begin
            if ((pmem_read || pmem_write) && !prev_busy) glog.push_back(pmem_address);
            prev_busy = pmem_read || pmem_write;
            if (i_mem_resp || d_mem_resp) begin
                check("resp_exclusive", {31'd0, i_mem_resp & d_mem_resp}, 32'd0);
                mon_have = (sb.size() != 0);
                check("resp_expected", {31'd0, mon_have}, 32'd1);
                if (mon_have) begin
                    mon_e = sb.pop_front();
                    check("resp_side", {31'd0, d_mem_resp}, {31'd0, mon_e.is_d});
                    if (mon_e.chk_data) begin
                        check("resp_data", {16'd0, (mon_e.is_d ? d_mem_rdata : i_mem_rdata)},
                              {16'd0, mon_e.data});
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] exp_order [6];
        int n;
        int k;
        rst = 1'b1;
        i_mem_read = 1'b0; i_mem_address = 16'h0000;
        d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_byte_enable = 2'b00;
        d_mem_address = 16'h0000; d_mem_wdata = 16'h0000;
        mem[16'h1000] = 16'hBEEF; mem[16'h2000] = 16'h2222; mem[16'h2001] = 16'h00CD;
        mem[16'h3000] = 16'h3333; mem[16'h1100] = 16'h1111; mem[16'h1200] = 16'h1212;
        mem[16'h1300] = 16'h1313;
        exp_order = '{16'h3000, 16'h3000, 16'h3000, 16'h3000, 16'h1100, 16'h3000};

        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", {26'd0, pmem_read, pmem_write, i_mem_resp, d_mem_resp, pmem_byte_enable}, 32'd0);
        check("rst_addr", {pmem_address, pmem_wdata}, 32'd0);
        check("rst_rdata", {i_mem_rdata, d_mem_rdata}, 32'd0);
        rst = 1'b0;
        tick();

        // 1: lone fetch, pmem answers in cycle 3, pulse in cycle 4
        lat = 3;
        i_mem_address = 16'h1000; i_mem_read = 1'b1;
        push(1'b0, 1'b1, 16'hBEEF);
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("t1_pmem_rw", {30'd0, pmem_read, pmem_write}, 32'd2);
            check("t1_addr", {16'd0, pmem_address}, 32'h1000);
            check("t1_no_resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
        end
        tick();
        check("t1_i_resp", {31'd0, i_mem_resp}, 32'd1);
        check("t1_rdata", {16'd0, i_mem_rdata}, 32'hBEEF);
        check("t1_d_quiet", {31'd0, d_mem_resp}, 32'd0);
        check("t1_pmem_drop", {31'd0, pmem_read}, 32'd0);
        i_mem_read = 1'b0;
        tick();
        check("t1_pulse_end", {31'd0, i_mem_resp}, 32'd0);
        check("t1_rdata_hold", {16'd0, i_mem_rdata}, 32'hBEEF);

        // 2: simultaneous I and D, D first
        lat = 2;
        d_mem_address = 16'h2000; d_mem_read = 1'b1;
        i_mem_address = 16'h1000; i_mem_read = 1'b1;
        push(1'b1, 1'b1, 16'h2222);
        push(1'b0, 1'b1, 16'hBEEF);
        tick();
        check("t2_d_first", {16'd0, pmem_address}, 32'h2000);
        wait_resp(10, "t2_d_timeout");
        check("t2_d_resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd1);
        d_mem_read = 1'b0;
        tick();
        check("t2_gap", {31'd0, pmem_read}, 32'd0);
        tick();
        check("t2_i_grant", {15'd0, pmem_read, pmem_address}, 32'h11000);
        wait_resp(10, "t2_i_timeout");
        check("t2_i_resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd2);
        i_mem_read = 1'b0;
        tick();

        // 3: continuous D with I waiting: D,D,D,D,I,D
        lat = 1;
        glog.delete();
        d_mem_address = 16'h3000; d_mem_read = 1'b1;
        i_mem_address = 16'h1100; i_mem_read = 1'b1;
        for (int j = 0; j < 4; j++) push(1'b1, 1'b1, 16'h3333);
        push(1'b0, 1'b1, 16'h1111);
        push(1'b1, 1'b1, 16'h3333);
        n = 0; k = 0;
        while (n < 6 && k < 200) begin
            tick();
            k++;
            if (i_mem_resp || d_mem_resp) n++;
        end
        check("t3_resp_count", n, 32'd6);
        d_mem_read = 1'b0; i_mem_read = 1'b0;
        tick(); tick();
        check("t3_grant_count", glog.size(), 32'd6);
        for (int j = 0; j < 6 && j < glog.size(); j++) begin
            check("t3_grant_order", {16'd0, glog[j]}, {16'd0, exp_order[j]});
        end

        // 4: fetch dropped mid-access, then a normal fetch
        lat = 3;
        i_mem_address = 16'h1200; i_mem_read = 1'b1;
        tick();
        check("t4_addr", {16'd0, pmem_address}, 32'h1200);
        tick();
        i_mem_read = 1'b0;
        tick();
        tick();
        check("t4_no_resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
        check("t4_rdata_hold", {16'd0, i_mem_rdata}, 32'h1111);
        check("t4_pmem_drop", {31'd0, pmem_read}, 32'd0);
        tick();
        check("t4_still_quiet", {31'd0, i_mem_resp}, 32'd0);
        lat = 1;
        i_mem_address = 16'h1300; i_mem_read = 1'b1;
        push(1'b0, 1'b1, 16'h1313);
        wait_resp(10, "t4_next_timeout");
        check("t4_next_rdata", {16'd0, i_mem_rdata}, 32'h1313);
        i_mem_read = 1'b0;
        tick();

        // 5: byte-lane write, request-side changes ignored while busy
        lat = 3;
        d_mem_address = 16'h2001; d_mem_wdata = 16'hAB00;
        d_mem_byte_enable = 2'b10; d_mem_write = 1'b1;
        push(1'b1, 1'b0, 16'h0000);
        tick();
        check("t5_pmem_rw", {30'd0, pmem_read, pmem_write}, 32'd1);
        check("t5_be", {30'd0, pmem_byte_enable}, 32'd2);
        check("t5_wdata", {16'd0, pmem_wdata}, 32'hAB00);
        check("t5_addr", {16'd0, pmem_address}, 32'h2001);
        d_mem_address = 16'h5555; d_mem_wdata = 16'h1234;
        tick();
        check("t5_addr_hold", {pmem_address, pmem_wdata}, 32'h2001AB00);
        wait_resp(10, "t5_timeout");
        check("t5_d_resp", {30'd0, i_mem_resp, d_mem_resp}, 32'd1);
        d_mem_write = 1'b0; d_mem_byte_enable = 2'b00;
        tick();
        lat = 2;
        d_mem_address = 16'h2001; d_mem_read = 1'b1;
        push(1'b1, 1'b1, 16'hABCD);
        tick();
        check("t5_read_be", {29'd0, pmem_read, pmem_byte_enable}, 32'd7);
        wait_resp(10, "t5_read_timeout");
        d_mem_read = 1'b0;
        tick();

        // 6: reset in the middle of a D access, then a standard fetch
        lat = 3;
        d_mem_address = 16'h2000; d_mem_read = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_ctl", {26'd0, pmem_read, pmem_write, i_mem_resp, d_mem_resp, pmem_byte_enable}, 32'd0);
        check("t6_rst_addr", {pmem_address, pmem_wdata}, 32'd0);
        check("t6_rst_rdata", {i_mem_rdata, d_mem_rdata}, 32'd0);
        d_mem_read = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        lat = 2;
        i_mem_address = 16'h1000; i_mem_read = 1'b1;
        push(1'b0, 1'b1, 16'hBEEF);
        tick();
        check("t6_grant", {15'd0, pmem_read, pmem_address}, 32'h11000);
        tick();
        check("t6_early", {30'd0, i_mem_resp, d_mem_resp}, 32'd0);
        tick();
        check("t6_i_resp", {15'd0, i_mem_resp, i_mem_rdata}, 32'h1BEEF);
        i_mem_read = 1'b0;
        tick();
        tick();

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
